// File: rtl/wb_pkg.sv
// Purpose: shared widths, register index/data types and pointer-width helper for the writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_S_INDEX = 5;
  localparam int WB_S_WIDTH = 32;

  typedef logic [WB_S_INDEX-1:0] reg_idx_t;
  typedef logic [WB_S_WIDTH-1:0] reg_data_t;

  // A one-source arbiter still needs a 1-bit pointer to keep the vector legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_select.sv
// Purpose: rotating scan that picks up to num_write_ports eligible sources, skipping same-dest clashes.
// Latency: purely combinational.
// Backpressure: sources not in grant must hold; next_ptr == rr_ptr when nothing is granted.
// Ports: elig (valid & dest!=0), rr_ptr, src_dest in; grant mask, per-port vld/source index, next_ptr out.
module wb_rr_select
  import wb_pkg::*;
#(
  parameter int num_srcs        = 4,
  parameter int num_write_ports = 3,
  parameter int s_index         = WB_S_INDEX,
  parameter int ptr_w           = 2
) (
  input  logic [num_srcs-1:0]        elig,
  input  logic [ptr_w-1:0]           rr_ptr,
  input  logic [s_index-1:0]         src_dest [num_srcs],
  output logic [num_srcs-1:0]        grant,
  output logic [num_write_ports-1:0] port_vld,
  output logic [ptr_w-1:0]           port_src [num_write_ports],
  output logic [ptr_w-1:0]           next_ptr
);

  int   idx;
  int   n_gnt;
  logic clash;

  // The outer loop walks scan positions; the inner loop over k turns the
  // rotated position back into a constant source index so every select is static.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    next_ptr = rr_ptr;
    idx      = 0;
    n_gnt    = 0;
    clash    = 1'b0;
    for (int j = 0; j < num_write_ports; j++) port_src[j] = '0;
    for (int i = 0; i < num_srcs; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= num_srcs) idx = idx - num_srcs;
      for (int k = 0; k < num_srcs; k++) begin
        if (k == idx && elig[k] && n_gnt < num_write_ports) begin
          // Only sources already granted this cycle can block a later one.
          clash = 1'b0;
          for (int m = 0; m < num_srcs; m++) begin
            if (grant[m] && src_dest[m] == src_dest[k]) clash = 1'b1;
          end
          if (!clash) begin
            grant[k] = 1'b1;
            for (int j = 0; j < num_write_ports; j++) begin
              if (j == n_gnt) begin
                port_src[j] = ptr_w'(k);
                port_vld[j] = 1'b1;
              end
            end
            n_gnt    = n_gnt + 1;
            next_ptr = (k == num_srcs - 1) ? '0 : ptr_w'(k + 1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose: round-robin writeback arbiter driving the regfile write ports; sole owner of ld/dest/in.
// Latency: accepted at edge N, wr_ld high during cycle N+1 (regfile commits at edge N+1).
// Backpressure: src_ready low for sources beyond the port budget or clashing on dest; x0 results always accepted.
// Ports: clk, rst (async high); src_valid/src_ready/src_dest/src_data per producer; wr_ld/wr_dest/wr_data per port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int s_index         = WB_S_INDEX,
  parameter int s_width         = WB_S_WIDTH,
  parameter int num_srcs        = 4,
  parameter int num_write_ports = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [num_srcs-1:0]        src_valid,
  output logic [num_srcs-1:0]        src_ready,
  input  logic [s_index-1:0]         src_dest [num_srcs],
  input  logic [s_width-1:0]         src_data [num_srcs],
  output logic [num_write_ports-1:0] wr_ld,
  output logic [s_index-1:0]         wr_dest  [num_write_ports],
  output logic [s_width-1:0]         wr_data  [num_write_ports]
);

  localparam int PW = ptr_width(num_srcs);

  logic [num_srcs-1:0]        elig;
  logic [num_srcs-1:0]        x0_hit;
  logic [num_srcs-1:0]        grant;
  logic [num_write_ports-1:0] port_vld;
  logic [PW-1:0]              port_src [num_write_ports];
  logic [PW-1:0]              next_ptr;

  logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [num_write_ports-1:0] wr_ld_q, wr_ld_d;
  logic [s_index-1:0]         wr_dest_q [num_write_ports];
  logic [s_index-1:0]         wr_dest_d [num_write_ports];
  logic [s_width-1:0]         wr_data_q [num_write_ports];
  logic [s_width-1:0]         wr_data_d [num_write_ports];

  // x0 results are swallowed without using a port or moving the pointer.
  always_comb begin
    for (int k = 0; k < num_srcs; k++) begin
      elig[k]   = src_valid[k] && (src_dest[k] != '0);
      x0_hit[k] = src_valid[k] && (src_dest[k] == '0);
    end
  end

  wb_rr_select #(
    .num_srcs        (num_srcs),
    .num_write_ports (num_write_ports),
    .s_index         (s_index),
    .ptr_w           (PW)
  ) u_sel (
    .elig     (elig),
    .rr_ptr   (rr_ptr_q),
    .src_dest (src_dest),
    .grant    (grant),
    .port_vld (port_vld),
    .port_src (port_src),
    .next_ptr (next_ptr)
  );

  // Nothing may be accepted while reset holds the output registers clear.
  assign src_ready = rst ? '0 : (grant | x0_hit);

  always_comb begin
    rr_ptr_d = next_ptr;
    wr_ld_d  = port_vld;
    for (int j = 0; j < num_write_ports; j++) begin
      wr_dest_d[j] = wr_dest_q[j];
      wr_data_d[j] = wr_data_q[j];
      if (port_vld[j]) begin
        wr_dest_d[j] = src_dest[port_src[j]];
        wr_data_d[j] = src_data[port_src[j]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wr_ld_q  <= '0;
      for (int j = 0; j < num_write_ports; j++) begin
        wr_dest_q[j] <= '0;
        wr_data_q[j] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ld_q  <= wr_ld_d;
      for (int j = 0; j < num_write_ports; j++) begin
        wr_dest_q[j] <= wr_dest_d[j];
        wr_data_q[j] <= wr_data_d[j];
      end
    end
  end

  assign wr_ld   = wr_ld_q;
  assign wr_dest = wr_dest_q;
  assign wr_data = wr_data_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter in front of the register file's write ports. It accepts results from `num_srcs` producers over valid/ready handshakes and grants at most `num_write_ports` of them per cycle. Selection is round-robin and fair. Granted writes are registered and presented on the regfile write ports one cycle later. It is the sole driver of the regfile `ld`/`dest`/`in` ports and resolves same-destination conflicts, which the regfile itself does not prioritise.

## Interface
Parameters:
- `s_index`, 5, register index width
- `s_width`, 32, data width
- `num_srcs`, 4, number of producers (must be ≥ `num_write_ports`)
- `num_write_ports`, 3, regfile write ports (`nwp`)

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `src_valid`  in  [num_srcs-1:0]  producer k holds a result
- `src_ready`  out  [num_srcs-1:0]  producer k's result is accepted this cycle
- `src_dest`  in  [s_index-1:0] x num_srcs (unpacked)  destination register
- `src_data`  in  [s_width-1:0] x num_srcs (unpacked)  result value
- `wr_ld`  out  [nwp-1:0]  regfile write enable per port
- `wr_dest`  out  [s_index-1:0] x nwp  regfile write index per port
- `wr_data`  out  [s_width-1:0] x nwp  regfile write data per port

## Operation
- **Handshake**
  - A transfer occurs when `src_valid[k] & src_ready[k]` are both high at a rising edge.
  - `src_ready` is combinational from `src_valid`/`src_dest` and `rr_ptr`.
  - Producers must not make `valid` depend on `ready`, and must hold `dest`/`data` stable while `valid` is high and `ready` is low.
- **x0 writes**
  - A valid source with `src_dest == 0` gets `src_ready = 1` in the same cycle.
  - It consumes no write port and is not counted by the pointer update.
- **Selection**
  - Scan sources in order `rr_ptr`, `rr_ptr+1`, … mod `num_srcs`.
  - A source is eligible if it is valid, has a nonzero dest, and no earlier-selected source this cycle has the same dest.
  - The first `nwp` eligible sources are granted.
  - The j-th granted source in scan order drives write port j; unused ports have `wr_ld = 0`.
- **Destination conflict**
  - Two valid sources with the same nonzero dest are never granted in the same cycle.
  - The one later in scan order waits with `ready = 0`.
- **Pointer update**
  - If at least one nonzero-dest grant occurred, `rr_ptr <= (index of last granted source + 1) mod num_srcs`.
  - Otherwise `rr_ptr` holds.
- **Output register**
  - Granted dest/data are captured into `wr_*` at the edge.
  - Non-granted ports register `wr_ld = 0`; `wr_dest`/`wr_data` on those ports retain their previous value.
- **Reset**
  - `rst` asynchronously clears `wr_ld`, `wr_dest`, `wr_data` and `rr_ptr` to 0, and forces `src_ready = 0`.
  - A registered-but-not-yet-applied write at reset assertion is discarded.

## Timing
- Latency: accept at edge N; `wr_ld` is high during cycle N+1; the regfile commits at edge N+1.
- Throughput: up to `nwp` nonzero-dest results per cycle, plus any number of x0 results.
- Starvation bound: a continuously valid source is granted within `num_srcs` cycles, absent dest conflicts.
- All valid with distinct dests, `num_srcs == nwp`: all ready every cycle.
- Pointer wrap: `rr_ptr = num_srcs-1` with a grant at the last index wraps to 0.
- Out of reset: `wr_ld = 0` on the first edge after deassertion; the arbiter is ready to accept in that first cycle.

## Structure
- Shared package `wb_pkg`: `s_index`/`s_width` defaults, and typedefs `reg_idx_t` and `reg_data_t`.
- Sub-module `wb_rr_select`: the rotating eligibility scan.
  - Inputs: eligible mask, `rr_ptr`, per-source dest.
  - Outputs: grant mask, per-port source index, next pointer.
  - Purely combinational.
- `wb_arbiter` holds the `rr_ptr` and output registers.

## Test plan
- **Reset:** assert `rst` mid-run with `wr_ld = 3'b011` pending → `wr_ld`, `wr_dest`, `wr_data` read 0 immediately; `src_ready = 0` while held; no regfile write occurs.
- **Basic round-robin:** 4 sources always valid, dests 1/2/3/4, `nwp = 3`:
  - Cycle 0 grants 0,1,2 and ptr becomes 3.
  - Cycle 1 grants 3,0,1 and ptr becomes 2.
  - `wr_dest` shows the matching values one cycle later.
- **Dest conflict:** src0 and src2 both dest 5, `rr_ptr = 0` → src0 granted, `src_ready[2] = 0`; next cycle src2 granted; the regfile holds src2's data last.
- **x0 drop:** src1 valid with dest 0, others idle → `src_ready[1] = 1`, `wr_ld = 0` next cycle, `rr_ptr` unchanged.
- **Wrap and backpressure:** `rr_ptr = 3`, only src3 and src0 valid with data `0xAAAA0003` and `0xAAAA0000` → port0 = src3, port1 = src0, ptr becomes 1; a held source's data is stable and written exactly once.
